// File: rtl/fdpe_pkg.sv
// fdpe_pkg: shared width limit and default reset/preset constants for fdpe_reg.
package fdpe_pkg;
    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DEF_RESET_VAL = '0;
    localparam logic [MAX_WIDTH-1:0] DEF_PRESET_VAL = '1;
endpackage

// File: rtl/fdpe_reg_if.sv
// fdpe_reg_if: data/enable/preset bundle for fdpe_reg; carries q_par when FDPE_REG_PARITY_EN is defined.
interface fdpe_reg_if #(parameter int WIDTH = 8) ();
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ce;
    logic [WIDTH-1:0] q;
    logic pre;
`ifdef FDPE_REG_PARITY_EN
    logic q_par;
    modport master (output d, ce, pre, input q, q_par);
    modport slave (input d, ce, pre, output q, q_par);
`else
    modport master (output d, ce, pre, input q);
    modport slave (input d, ce, pre, output q);
`endif
endinterface

// File: rtl/fdpe_bit.sv
// fdpe_bit: one D flop with clock enable, async active-high preset and async active-low reset.
module fdpe_bit #(
    parameter logic RESET_VAL = 1'b0,
    parameter logic PRESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pre,
    input  logic ce,
    input  logic d,
    output logic q
);
    // gating pre with reset_n makes reset release under pre raise a preset edge
    logic set;
    assign set = pre & reset_n;
    always_ff @(posedge clock or negedge reset_n or posedge set) begin
        if (!reset_n) q <= RESET_VAL;
        else if (set) q <= PRESET_VAL;
        else if (ce) q <= d;
    end
endmodule

// File: rtl/fdpe_reg.sv
// fdpe_reg: WIDTH-bit register of independent fdpe_bit flops with per-bit clock enable.
// Define FDPE_REG_PARITY_EN to add the even-parity output q_par.
module fdpe_reg import fdpe_pkg::*; #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL[WIDTH-1:0],
    parameter logic [WIDTH-1:0] PRESET_VAL = DEF_PRESET_VAL[WIDTH-1:0]
) (
    input  logic clock,
    input  logic reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] ce,
    input  logic pre,
    output logic [WIDTH-1:0] q
`ifdef FDPE_REG_PARITY_EN
    ,
    output logic q_par
`endif
);
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("fdpe_reg: WIDTH out of range");
    end
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        fdpe_bit #(.RESET_VAL(RESET_VAL[g]), .PRESET_VAL(PRESET_VAL[g])) u_bit (
            .clock(clock),
            .reset_n(reset_n),
            .pre(pre),
            .ce(ce[g]),
            .d(d[g]),
            .q(q[g])
        );
    end
`ifdef FDPE_REG_PARITY_EN
    assign q_par = ^q;
`endif
endmodule

// File: tb/tb_fdpe_reg.sv
// tb_fdpe_reg: directed scoreboard bench for fdpe_reg at WIDTH=1 and WIDTH=8.
module tb_fdpe_reg;
    typedef struct {
        string name;
        bit w8;
        logic [7:0] q;
        logic par;
        bit cp;
    } exp_t;

    logic clock = 1'b0;
    logic rst1_n = 1'b0;
    logic rst8_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    event sample;

    fdpe_reg_if #(.WIDTH(1)) if1 ();
    fdpe_reg_if #(.WIDTH(8)) if8 ();

    always #5 clock = ~clock;

    fdpe_reg #(.WIDTH(1)) u1 (
        .clock(clock), .reset_n(rst1_n), .d(if1.d), .ce(if1.ce), .pre(if1.pre), .q(if1.q)
`ifdef FDPE_REG_PARITY_EN
        , .q_par(if1.q_par)
`endif
    );

    fdpe_reg #(.WIDTH(8)) u8 (
        .clock(clock), .reset_n(rst8_n), .d(if8.d), .ce(if8.ce), .pre(if8.pre), .q(if8.q)
`ifdef FDPE_REG_PARITY_EN
        , .q_par(if8.q_par)
`endif
    );

    task automatic chk(input string name, input bit w8, input logic [7:0] q, input logic par, input bit cp);
        exp_t e;
        e.name = name;
        e.w8 = w8;
        e.q = q;
        e.par = par;
        e.cp = cp;
        sb.push_back(e);
        -> sample;
    endtask

    task automatic edge_chk();
        @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(sample);
            while (sb.size() > 0) begin
                exp_t e;
                logic [7:0] got;
                e = sb.pop_front();
                got = e.w8 ? if8.q : {7'b0, if1.q};
                checks++;
                if (got !== e.q) begin
                    errors++;
                    $display("FAIL %s: q got %h expected %h", e.name, got, e.q);
                end
`ifdef FDPE_REG_PARITY_EN
                if (e.cp) begin
                    checks++;
                    if (if8.q_par !== e.par) begin
                        errors++;
                        $display("FAIL %s_par: q_par got %b expected %b", e.name, if8.q_par, e.par);
                    end
                end
`endif
            end
        end
    end

    initial begin
        if1.d = '0; if1.ce = '0; if1.pre = 1'b0;
        if8.d = '0; if8.ce = '0; if8.pre = 1'b0;
        #1;
        chk("reset1", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset8", 1'b1, 8'h00, 1'b0, 1'b1);
        @(negedge clock);
        rst1_n = 1'b1;
        #1 chk("release1", 1'b0, 8'h00, 1'b0, 1'b0);
        // single-bit capture
        if1.d = 1'b1; if1.ce = 1'b1;
        edge_chk(); chk("cap1", 1'b0, 8'h01, 1'b0, 1'b0);
        @(negedge clock); if1.d = 1'b0;
        edge_chk(); chk("cap0", 1'b0, 8'h00, 1'b0, 1'b0);
        // async preset mid-cycle
        @(negedge clock); if1.d = 1'b0; if1.ce = 1'b1;
        #2 if1.pre = 1'b1;
        #1 chk("pre_async", 1'b0, 8'h01, 1'b0, 1'b0);
        edge_chk(); chk("pre_hold", 1'b0, 8'h01, 1'b0, 1'b0);
        @(negedge clock); if1.d = 1'b1;
        edge_chk(); chk("pre_d1", 1'b0, 8'h01, 1'b0, 1'b0);
        @(negedge clock); if1.pre = 1'b0; if1.d = 1'b0; if1.ce = 1'b0;
        #1 chk("pre_release", 1'b0, 8'h01, 1'b0, 1'b0);
        // clock-enable hold
        @(negedge clock); if1.d = 1'b1; if1.ce = 1'b0;
        edge_chk(); chk("ce0_a", 1'b0, 8'h01, 1'b0, 1'b0);
        edge_chk(); chk("ce0_b", 1'b0, 8'h01, 1'b0, 1'b0);
        @(negedge clock); if1.d = 1'b0;
        edge_chk(); chk("ce0_d0", 1'b0, 8'h01, 1'b0, 1'b0);
        @(negedge clock); if1.ce = 1'b1;
        #1 chk("ce1_pre_edge", 1'b0, 8'h01, 1'b0, 1'b0);
        edge_chk(); chk("ce1_load", 1'b0, 8'h00, 1'b0, 1'b0);
        // reset wins over preset, release under preset
        @(negedge clock); if8.pre = 1'b1;
        #1 chk("rst_over_pre", 1'b1, 8'h00, 1'b0, 1'b1);
        edge_chk(); chk("rst_over_pre_edge", 1'b1, 8'h00, 1'b0, 1'b1);
        @(negedge clock); rst8_n = 1'b1;
        #1 chk("release_to_pre", 1'b1, 8'hFF, 1'b0, 1'b1);
        @(negedge clock); if8.pre = 1'b0; if8.d = 8'h00; if8.ce = 8'hFF;
        #1 chk("pre8_release", 1'b1, 8'hFF, 1'b0, 1'b1);
        edge_chk(); chk("clear8", 1'b1, 8'h00, 1'b0, 1'b1);
        // per-bit enables
        @(negedge clock); if8.d = 8'hA5; if8.ce = 8'h0F;
        edge_chk(); chk("a5_ce0f", 1'b1, 8'h05, 1'b0, 1'b1);
        @(negedge clock); if8.d = 8'h01; if8.ce = 8'hFF;
        edge_chk(); chk("load01", 1'b1, 8'h01, 1'b1, 1'b1);
        @(negedge clock); if8.d = 8'hFF; if8.ce = 8'hA0;
        edge_chk(); chk("ff_cea0", 1'b1, 8'hA1, 1'b1, 1'b1);
        @(negedge clock); if8.d = 8'h3C; if8.ce = 8'h00;
        edge_chk(); chk("hold8", 1'b1, 8'hA1, 1'b1, 1'b1);
        #2 rst8_n = 1'b0;
        #1 chk("async_reset8", 1'b1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 100 && sb.size() > 0; i++) #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fdpe_reg.md
FDPE_REG -- requirements
Module: fdpe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of flop bits, legal range 1..64.
REQ-002 SHALL have parameter RESET_VAL, default all zeros: q value while reset_n is low.
REQ-003 SHALL have parameter PRESET_VAL, default all ones: q value while pre is high.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port d, input, WIDTH bits: data to capture.
REQ-007 SHALL have port ce, input, WIDTH bits: per-bit clock enable, active high.
REQ-008 SHALL have port pre, input, 1 bit: asynchronous active-high preset, applied to all bits.
REQ-009 SHALL have port q, output, WIDTH bits: registered data.
REQ-010 SHALL have port q_par, output, 1 bit, present only with FDPE_REG_PARITY_EN: even parity of q.

Function
REQ-011 SHALL, on each clock rising edge with reset_n high and pre low, load d[i] into q[i] for every i where ce[i]=1.
REQ-012 SHALL hold q[i] unchanged on an edge where ce[i]=0.
REQ-013 SHALL drive q to PRESET_VAL immediately on pre high, independent of clock, ce and d, and hold it while pre stays high.
REQ-014 SHALL keep q at PRESET_VAL after pre deasserts until the next clock edge with the corresponding ce bit set; no extra latency.
REQ-015 SHALL give reset_n low priority over pre: with both asserted, q=RESET_VAL.
REQ-016 SHALL, when reset_n is released while pre is high, go to PRESET_VAL asynchronously.
REQ-017 SHALL exhibit capture latency d->q of exactly one clock edge; q changes only on a clock edge or an async reset/preset event.
REQ-018 SHALL behave identically for every bit; bits are independent except for the shared pre and reset_n.

Reset
REQ-019 SHALL force q=RESET_VAL asynchronously while reset_n=0; with FDPE_REG_PARITY_EN, q_par=^RESET_VAL during reset.
REQ-020 SHALL make reset deassertion take effect without clock; the first capture occurs on the first rising edge after release.

Configuration
REQ-021 SHALL include port q_par and its XOR reduction when macro FDPE_REG_PARITY_EN is defined; without it, the port and logic are absent and the port list is clock, reset_n, d, ce, pre, q.
REQ-022 SHALL compute q_par combinationally from q, so it tracks every q change including async reset/preset.

Structure
REQ-023 SHALL place the WIDTH maximum constant and the default RESET_VAL/PRESET_VAL constants in shared package fdpe_pkg.
REQ-024 SHALL implement each bit as sub-module fdpe_bit (1-bit D flop, CE, async preset, async active-low reset), instantiated WIDTH times by generate.
REQ-025 SHALL contain no latches or combinational feedback; synthesizable as WIDTH flops with async set/clear.

Verification
REQ-026 WIDTH=1: reset_n=0 then 1; d=1, ce=1, pre=0, one edge -> q=1; then d=0, one edge -> q=0.
REQ-027 WIDTH=1: d=0, ce=1, pre=1 mid-cycle -> q=1 before the next edge, and stays 1 across edges; d=1, pre=1 -> q=1.
REQ-028 WIDTH=1: q=1, d=1, ce=0 for two edges -> q stays 1; d=0, ce=0 -> q stays 1; then ce=1 -> q=0 after one edge.
REQ-029 WIDTH=8: pre=1 and reset_n=0 together -> q=8'h00; release reset_n with pre=1 -> q=8'hFF immediately.
REQ-030 WIDTH=8: q=8'h00, d=8'hA5, ce=8'h0F, one edge -> q=8'h05; with FDPE_REG_PARITY_EN, q_par=0; then d=8'h01, ce=8'hFF -> q_par=1.
